// File: rtl/vend_pkg.sv
// -----------------------------------------------------------------------------
// vend_pkg
// Shared types for the vending actuator sequencer.
//   channel_t : actuator channel numbering (matches actuator_sel encoding)
//   state_t   : sequencer FSM states
//   max2      : constant helper used for timer sizing
// -----------------------------------------------------------------------------
package vend_pkg;

    localparam int NUM_CH = 4;

    typedef enum logic [1:0] {
        CH_JOLT   = 2'd0,
        CH_BUZZ   = 2'd1,
        CH_NICKEL = 2'd2,
        CH_DIME   = 2'd3
    } channel_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        GAP  = 2'd2
    } state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/vend_rr_arbiter.sv
// -----------------------------------------------------------------------------
// vend_rr_arbiter
// Combinational 4-way round-robin arbiter. The search starts at ptr+1 (mod 4)
// and wraps, so the channel at ptr has the lowest priority.
// Ports:
//   req        in  4  request vector, bit i = channel i wants service
//   ptr        in  2  last granted channel
//   gnt_onehot out 4  one-hot grant (0 when nothing requested)
//   gnt_idx    out 2  encoded grant (0 when nothing requested)
//   gnt_valid  out 1  some channel was granted
// -----------------------------------------------------------------------------
module vend_rr_arbiter
    import vend_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [1:0]        ptr,
    output logic [NUM_CH-1:0] gnt_onehot,
    output logic [1:0]        gnt_idx,
    output logic              gnt_valid
);

    always_comb begin
        gnt_idx   = 2'd0;
        gnt_valid = 1'b0;
        // Scan from the farthest candidate (ptr itself) to the nearest
        // (ptr+1); the last hit wins, so the nearest requester is granted.
        for (int k = NUM_CH; k >= 1; k--) begin
            if (req[ptr + 2'(k)]) begin
                gnt_idx   = ptr + 2'(k);
                gnt_valid = 1'b1;
            end
        end
        gnt_onehot = gnt_valid ? (4'b0001 << gnt_idx) : 4'b0000;
    end

endmodule

// File: rtl/vend_dispense_sequencer.sv
// -----------------------------------------------------------------------------
// vend_dispense_sequencer
// Schedules the single shared solenoid driver between two product dispensers
// and two coin-return chutes. One-cycle requests are counted per channel in
// 2-bit saturating counters, arbitrated round-robin, and turned into
// PULSE_CYCLES-long fire pulses followed by GAP_CYCLES of recovery and one
// IDLE cycle before the next grant.
// Parameters:
//   PULSE_CYCLES  cycles actuator_fire stays high per service (>=1)
//   GAP_CYCLES    idle cycles after each pulse (>=1)
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   req_jolt/buzz/nickel/dime  one-cycle service requests, channels 0..3
//   actuator_sel   channel being driven, 0 when not firing (registered)
//   actuator_fire  solenoid enable (registered)
//   busy           high in FIRE or GAP (registered)
//   pending        bit i = channel i has outstanding requests (combinational)
//   overflow       one-cycle pulse, a request was dropped (registered)
//   served_count   completed services, wraps at 256 (only when the macro
//                  VEND_SEQ_STATS_EN is defined)
// The FSM state is held in the signal 'state' (type state_t) for probing.
// -----------------------------------------------------------------------------
module vend_dispense_sequencer
    import vend_pkg::*;
#(
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_jolt,
    input  logic       req_buzz,
    input  logic       req_nickel,
    input  logic       req_dime,
    output logic [1:0] actuator_sel,
    output logic       actuator_fire,
    output logic       busy,
    output logic [3:0] pending,
    output logic       overflow
`ifdef VEND_SEQ_STATS_EN
    ,
    output logic [7:0] served_count
`endif
);

    localparam int TW = $clog2(max2(PULSE_CYCLES, GAP_CYCLES)) + 1;
    localparam logic [TW-1:0] PULSE_LAST = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_CYCLES - 1);

    state_t                  state, state_nx;
    logic [TW-1:0]           timer, timer_nx;
    logic [NUM_CH-1:0][1:0]  cnt, cnt_nx;
    logic [NUM_CH-1:0]       req_vec;
    logic [NUM_CH-1:0]       drop;
    logic [NUM_CH-1:0]       gnt_onehot;
    logic [1:0]              gnt_idx;
    logic                    gnt_valid;
    logic                    grant;
    // Last granted channel: doubles as the round-robin pointer and as the
    // channel driven for the whole FIRE phase.
    logic [1:0]              ptr;
    logic [1:0]              ch_nx;

    assign req_vec = {req_dime, req_nickel, req_buzz, req_jolt};

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            pending[i] = (cnt[i] != 2'd0);
        end
    end

    vend_rr_arbiter u_arb (
        .req        (pending),
        .ptr        (ptr),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .gnt_valid  (gnt_valid)
    );

    // Next-state logic. The timer is loaded with (length-1) on entry to a
    // phase and the phase ends on the edge where it reads zero.
    always_comb begin
        state_nx = state;
        timer_nx = timer;
        grant    = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_valid) begin
                    grant    = 1'b1;
                    state_nx = FIRE;
                    timer_nx = PULSE_LAST;
                end
            end
            FIRE: begin
                if (timer == '0) begin
                    state_nx = GAP;
                    timer_nx = GAP_LAST;
                end else begin
                    timer_nx = timer - 1'b1;
                end
            end
            GAP: begin
                if (timer == '0) begin
                    state_nx = IDLE;
                    timer_nx = '0;
                end else begin
                    timer_nx = timer - 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                timer_nx = '0;
            end
        endcase
    end

    assign ch_nx = grant ? gnt_idx : ptr;

    // Pending counters: a request and a grant on the same edge cancel; a
    // request into a full counter with no grant is dropped.
    always_comb begin
        cnt_nx = cnt;
        drop   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            case ({req_vec[i], grant & gnt_onehot[i]})
                2'b10: begin
                    if (cnt[i] == 2'd3) drop[i] = 1'b1;
                    else                cnt_nx[i] = cnt[i] + 2'd1;
                end
                2'b01:   cnt_nx[i] = cnt[i] - 2'd1;
                default: ;
            endcase
        end
    end

    // Outputs are registered from next-state values so they line up with
    // the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            timer         <= '0;
            cnt           <= '0;
            ptr           <= 2'd3;
            actuator_fire <= 1'b0;
            actuator_sel  <= 2'd0;
            busy          <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            state         <= state_nx;
            timer         <= timer_nx;
            cnt           <= cnt_nx;
            ptr           <= ch_nx;
            actuator_fire <= (state_nx == FIRE);
            actuator_sel  <= (state_nx == FIRE) ? ch_nx : 2'd0;
            busy          <= (state_nx != IDLE);
            overflow      <= |drop;
        end
    end

`ifdef VEND_SEQ_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            served_count <= 8'd0;
        end else if (state == FIRE && state_nx == GAP) begin
            served_count <= served_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vend_dispense_sequencer.sv
module tb_vend_dispense_sequencer;

    localparam int P = 4;
    localparam int G = 2;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_jolt = 1'b0, req_buzz = 1'b0, req_nickel = 1'b0, req_dime = 1'b0;
    logic [1:0] actuator_sel;
    logic       actuator_fire;
    logic       busy;
    logic [3:0] pending;
    logic       overflow;
`ifdef VEND_SEQ_STATS_EN
    logic [7:0] served_count;
`endif

    always #5 clk = ~clk;

    vend_dispense_sequencer #(.PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_jolt      (req_jolt),
        .req_buzz      (req_buzz),
        .req_nickel    (req_nickel),
        .req_dime      (req_dime),
        .actuator_sel  (actuator_sel),
        .actuator_fire (actuator_fire),
        .busy          (busy),
        .pending       (pending),
        .overflow      (overflow)
`ifdef VEND_SEQ_STATS_EN
        ,
        .served_count  (served_count)
`endif
    );

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [8:0] outs();
        return {actuator_fire, actuator_sel, busy, pending, overflow};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] r);
        {req_dime, req_nickel, req_buzz, req_jolt} = r;
    endtask

    task automatic do_reset();
        drive(4'b0000);
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // ---------------- reference model ----------------
    // m_t counts cycles into the current service window: 0 = idle,
    // 1..P = firing, P+1..P+G = recovering.
    int m_cnt[4];
    int m_t, m_ch, m_ptr, m_served;
    bit m_ovf;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        m_t = 0; m_ch = 0; m_ptr = 3; m_served = 0; m_ovf = 0;
    endtask

    task automatic model_edge(input logic [3:0] r);
        bit g = 0;
        int w = 0;
        if (m_t == 0) begin
            for (int k = 1; k <= 4; k++) begin
                int c;
                c = (m_ptr + k) % 4;
                if (!g && m_cnt[c] != 0) begin g = 1; w = c; end
            end
        end
        m_ovf = 0;
        for (int i = 0; i < 4; i++) begin
            bit inc, dec;
            inc = r[i];
            dec = g && (w == i);
            if (inc && !dec) begin
                if (m_cnt[i] == 3) m_ovf = 1;
                else m_cnt[i]++;
            end else if (dec && !inc) begin
                m_cnt[i]--;
            end
        end
        if (g) begin
            m_t = 1; m_ch = w; m_ptr = w;
        end else if (m_t != 0) begin
            if (m_t == P) m_served++;
            m_t = (m_t == P + G) ? 0 : m_t + 1;
        end
    endtask

    function automatic logic [8:0] model_outs();
        logic f;
        logic [3:0] pe;
        f = (m_t >= 1) && (m_t <= P);
        for (int i = 0; i < 4; i++) pe[i] = (m_cnt[i] != 0);
        return {f, f ? 2'(m_ch) : 2'd0, (m_t != 0), pe, m_ovf};
    endfunction

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [3:0] req;
        logic       fire;
        logic [1:0] sel;
        logic       busy;
        logic [3:0] pend;
        logic       ovf;
    } vec_t;

    vec_t tbl[23];

    initial begin
        logic prev_fire;
        int   buzz_fires;
        bit   found;
        // jolt + dime together after reset, then a lone nickel
        tbl[0]  = '{4'b1001, 1'b0, 2'd0, 1'b0, 4'b1001, 1'b0};
        tbl[1]  = '{4'b0000, 1'b1, 2'd0, 1'b1, 4'b1000, 1'b0};
        tbl[2]  = '{4'b0000, 1'b1, 2'd0, 1'b1, 4'b1000, 1'b0};
        tbl[3]  = '{4'b0000, 1'b1, 2'd0, 1'b1, 4'b1000, 1'b0};
        tbl[4]  = '{4'b0000, 1'b1, 2'd0, 1'b1, 4'b1000, 1'b0};
        tbl[5]  = '{4'b0000, 1'b0, 2'd0, 1'b1, 4'b1000, 1'b0};
        tbl[6]  = '{4'b0000, 1'b0, 2'd0, 1'b1, 4'b1000, 1'b0};
        tbl[7]  = '{4'b0000, 1'b0, 2'd0, 1'b0, 4'b1000, 1'b0};
        tbl[8]  = '{4'b0000, 1'b1, 2'd3, 1'b1, 4'b0000, 1'b0};
        tbl[9]  = '{4'b0000, 1'b1, 2'd3, 1'b1, 4'b0000, 1'b0};
        tbl[10] = '{4'b0000, 1'b1, 2'd3, 1'b1, 4'b0000, 1'b0};
        tbl[11] = '{4'b0000, 1'b1, 2'd3, 1'b1, 4'b0000, 1'b0};
        tbl[12] = '{4'b0000, 1'b0, 2'd0, 1'b1, 4'b0000, 1'b0};
        tbl[13] = '{4'b0000, 1'b0, 2'd0, 1'b1, 4'b0000, 1'b0};
        tbl[14] = '{4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0};
        tbl[15] = '{4'b0100, 1'b0, 2'd0, 1'b0, 4'b0100, 1'b0};
        tbl[16] = '{4'b0000, 1'b1, 2'd2, 1'b1, 4'b0000, 1'b0};
        tbl[17] = '{4'b0000, 1'b1, 2'd2, 1'b1, 4'b0000, 1'b0};
        tbl[18] = '{4'b0000, 1'b1, 2'd2, 1'b1, 4'b0000, 1'b0};
        tbl[19] = '{4'b0000, 1'b1, 2'd2, 1'b1, 4'b0000, 1'b0};
        tbl[20] = '{4'b0000, 1'b0, 2'd0, 1'b1, 4'b0000, 1'b0};
        tbl[21] = '{4'b0000, 1'b0, 2'd0, 1'b1, 4'b0000, 1'b0};
        tbl[22] = '{4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0};

        // ---- reset state ----
        drive(4'b0000);
        rst_n = 1'b0;
        step();
        check("in_reset", 32'(outs()), 32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("idle_after_reset%0d", i), 32'(outs()), 32'd0);
        end
`ifdef VEND_SEQ_STATS_EN
        check("served_reset", 32'(served_count), 32'd0);
`endif

        // ---- table ----
        for (int i = 0; i < 23; i++) begin
            drive(tbl[i].req);
            step();
            check($sformatf("vec%0d", i), 32'(outs()),
                  32'({tbl[i].fire, tbl[i].sel, tbl[i].busy, tbl[i].pend, tbl[i].ovf}));
        end

        // ---- saturation while busy with nickel ----
        do_reset();
        drive(4'b0100); step();
        drive(4'b0000); step();
        check("sat_nickel_fire", 32'({actuator_fire, actuator_sel}), 32'({1'b1, 2'd2}));
        for (int i = 0; i < 3; i++) begin
            drive(4'b0010); step();
            check($sformatf("sat_ovf_low%0d", i), 32'(overflow), 32'd0);
        end
        check("sat_pending", 32'(pending), 32'b0010);
        drive(4'b0010); step();
        check("sat_ovf_pulse", 32'(overflow), 32'd1);
        drive(4'b0000); step();
        check("sat_ovf_clear", 32'(overflow), 32'd0);
        buzz_fires = 0;
        prev_fire  = actuator_fire;
        for (int i = 0; i < 60; i++) begin
            step();
            if (actuator_fire && !prev_fire && actuator_sel == 2'd1) buzz_fires++;
            prev_fire = actuator_fire;
        end
        check("sat_buzz_services", 32'(buzz_fires), 32'd3);
        check("sat_drained", 32'({busy, pending}), 32'd0);

        // ---- reset during FIRE ----
        do_reset();
        drive(4'b1000); step();
        drive(4'b0010); step();
        drive(4'b0000); step();
        check("rst_pre_fire", 32'({actuator_fire, actuator_sel, pending}), 32'({1'b1, 2'd3, 4'b0010}));
        rst_n = 1'b0;
        #1;
        check("rst_async_drop", 32'(outs()), 32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("rst_after%0d", i), 32'(outs()), 32'd0);
        end

        // ---- continuous requests on all channels: strict rotation ----
        do_reset();
        drive(4'b1111);
        prev_fire = actuator_fire;
        for (int s = 0; s < 260; s++) begin
            found = 0;
            for (int c = 0; c < 20 && !found; c++) begin
                step();
                if (actuator_fire && !prev_fire) found = 1;
                prev_fire = actuator_fire;
            end
            if (!found) begin
                check($sformatf("rot_timeout%0d", s), 32'd0, 32'd1);
                break;
            end
            check($sformatf("rot_sel%0d", s), 32'(actuator_sel), 32'(s % 4));
`ifdef VEND_SEQ_STATS_EN
            check($sformatf("rot_served%0d", s), 32'(served_count), 32'(s % 256));
`endif
        end
        drive(4'b0000);

        // ---- randomized traffic against the reference model ----
        do_reset();
        model_reset();
        for (int blk = 0; blk < 10; blk++) begin
            int dens;
            dens = $urandom_range(1, 9);
            for (int c = 0; c < 200; c++) begin
                logic [3:0] r;
                for (int i = 0; i < 4; i++) r[i] = ($urandom_range(0, dens) == 0);
                drive(r);
                step();
                model_edge(r);
                exp_q.push_back(model_outs());
                check($sformatf("rand%0d_%0d", blk, c), 32'(outs()), 32'(exp_q.pop_front()));
`ifdef VEND_SEQ_STATS_EN
                check($sformatf("rand_served%0d_%0d", blk, c), 32'(served_count), 32'(m_served % 256));
`endif
            end
        end
        drive(4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
